// File: rtl/jtexterm_romrq.sv
// Main-CPU ROM fetch handshake: registers SDRAM requests, drops the stale rom_ok after an
// address change, keeps a one-entry hit cache and freezes the CPU enable while a fetch is outstanding.
module jtexterm_romrq #(
  parameter int AW   = 17,
  parameter int DW   = 8,
  parameter int TOUT = 255
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cen,
  input  logic          cpu_cs,
  input  logic [AW-1:0] cpu_addr,
  output logic          cpu_cen,
  output logic [DW-1:0] cpu_data,
  output logic          stall,
  output logic          rom_cs,
  output logic [AW-1:0] rom_addr,
  input  logic          rom_ok,
  input  logic [DW-1:0] rom_data,
  output logic          tout_err
);

  localparam logic [7:0] TOUT_C = 8'(TOUT);

  typedef enum logic [1:0] {IDLE, ARM, WAIT} state_t;

  state_t        state_q, state_d;
  logic          rom_cs_q, rom_cs_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic          stall_q, stall_d;
  logic [DW-1:0] cpu_data_q, cpu_data_d;
  logic          cache_v_q, cache_v_d;
  logic [AW-1:0] cache_a_q, cache_a_d;
  logic [DW-1:0] cache_d_q, cache_d_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          terr_q, terr_d;

  logic hit, miss;

  assign hit  = cpu_cs & cache_v_q & (cpu_addr == cache_a_q);
  assign miss = (state_q == IDLE) & cpu_cs & ~hit;

  always_comb begin
    state_d    = state_q;
    rom_cs_d   = rom_cs_q;
    rom_addr_d = rom_addr_q;
    stall_d    = stall_q;
    cpu_data_d = cpu_data_q;
    cache_v_d  = cache_v_q;
    cache_a_d  = cache_a_q;
    cache_d_d  = cache_d_q;
    cnt_d      = cnt_q;
    terr_d     = terr_q;
    case (state_q)
      IDLE: begin
        if (miss) begin
          // Drop the old entry now so a timed-out fetch can never leave a stale hit behind
          state_d    = ARM;
          rom_cs_d   = 1'b1;
          rom_addr_d = cpu_addr;
          stall_d    = 1'b1;
          cnt_d      = 8'd0;
          cache_v_d  = 1'b0;
        end
      end
      ARM: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (rom_ok) begin
          cpu_data_d = rom_data;
          cache_v_d  = 1'b1;
          cache_a_d  = rom_addr_q;
          cache_d_d  = rom_data;
          rom_cs_d   = 1'b0;
          stall_d    = 1'b0;
          state_d    = IDLE;
        end else if (cnt_q >= TOUT_C) begin
          cpu_data_d = {DW{1'b1}};
          terr_d     = 1'b1;
          rom_cs_d   = 1'b0;
          stall_d    = 1'b0;
          state_d    = IDLE;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        rom_cs_d = 1'b0;
        stall_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      rom_cs_q   <= 1'b0;
      rom_addr_q <= '0;
      stall_q    <= 1'b0;
      cpu_data_q <= {DW{1'b1}};
      cache_v_q  <= 1'b0;
      cache_a_q  <= '0;
      cache_d_q  <= '0;
      cnt_q      <= 8'd0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_cs_q   <= rom_cs_d;
      rom_addr_q <= rom_addr_d;
      stall_q    <= stall_d;
      cpu_data_q <= cpu_data_d;
      cache_v_q  <= cache_v_d;
      cache_a_q  <= cache_a_d;
      cache_d_q  <= cache_d_d;
      cnt_q      <= cnt_d;
      terr_q     <= terr_d;
    end
  end

  // A miss freezes the CPU in the very cycle it is seen, ahead of the registered stall
  assign stall    = stall_q | miss;
  assign cpu_cen  = cen & ~stall;
  assign cpu_data = cpu_data_q;
  assign rom_cs   = rom_cs_q;
  assign rom_addr = rom_addr_q;
  assign tout_err = terr_q;

endmodule

// File: tb/tb_jtexterm_romrq.sv
// Directed and randomized fetch transactions against a transaction-level model of the
// ROM request block: expected stall length, cache contents, data and error flag.
module tb_jtexterm_romrq;
  localparam int AW   = 17;
  localparam int DW   = 8;
  localparam int TOUT = 255;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cen = 1'b0;
  logic          cpu_cs = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic          rom_ok = 1'b0;
  logic [DW-1:0] rom_data = '0;
  logic          cpu_cen, stall, rom_cs, tout_err;
  logic [DW-1:0] cpu_data;
  logic [AW-1:0] rom_addr;

  int tests = 0;
  int fails = 0;

  bit          cache_v = 1'b0;
  logic [AW-1:0] cache_a = '0;
  logic [DW-1:0] cache_d = '0;
  logic [DW-1:0] exp_data = 8'hFF;
  bit          exp_terr = 1'b0;
  int          stall_seen = 0;

  jtexterm_romrq #(.AW(AW), .DW(DW), .TOUT(TOUT)) dut (
    .clk(clk), .rstn(rstn), .cen(cen), .cpu_cs(cpu_cs), .cpu_addr(cpu_addr),
    .cpu_cen(cpu_cen), .cpu_data(cpu_data), .stall(stall), .rom_cs(rom_cs),
    .rom_addr(rom_addr), .rom_ok(rom_ok), .rom_data(rom_data), .tout_err(tout_err)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs already driven by the caller; checks at the falling edge.
  task automatic tick(input bit es, input bit ers, input logic [AW-1:0] era);
    cen = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("stall", {31'd0, stall}, {31'd0, es});
    check("cpu_cen", {31'd0, cpu_cen}, {31'd0, cen & ~es});
    check("rom_cs", {31'd0, rom_cs}, {31'd0, ers});
    if (ers) check("rom_addr", {15'd0, rom_addr}, {15'd0, era});
    check("cpu_data", {24'd0, cpu_data}, {24'd0, exp_data});
    check("tout_err", {31'd0, tout_err}, {31'd0, exp_terr});
    if (stall === 1'b1) stall_seen++;
    @(posedge clk);
    #1;
  endtask

  // lat = index of the WAIT cycle carrying rom_ok; lat > TOUT means rom_ok never comes.
  task automatic access(input logic [AW-1:0] a, input int lat, input bit stale,
                        input logic [DW-1:0] d);
    bit hit;
    int nwait;
    hit = cache_v && (cache_a == a);
    cpu_cs   = 1'b1;
    cpu_addr = a;
    if (hit) begin
      for (int i = 0; i < 2; i++) begin
        rom_ok   = 1'($urandom);
        rom_data = 8'($urandom);
        tick(1'b0, 1'b0, a);
      end
      $display("[TB] hit   addr=%05h data=%02h", a, cache_d);
      return;
    end
    stall_seen = 0;
    rom_ok   = stale ? 1'b1 : 1'($urandom);
    rom_data = 8'($urandom);
    tick(1'b1, 1'b0, a);
    cpu_addr = a ^ 17'h1;
    rom_ok   = stale;
    rom_data = ~d;
    tick(1'b1, 1'b1, a);
    nwait = (lat > TOUT) ? TOUT + 1 : lat + 1;
    for (int k = 0; k < nwait; k++) begin
      cpu_addr = 17'($urandom);
      rom_ok   = (k == lat);
      rom_data = (k == lat) ? d : 8'($urandom);
      tick(1'b1, 1'b1, a);
    end
    if (lat <= TOUT) begin
      cache_v = 1'b1; cache_a = a; cache_d = d; exp_data = d;
    end else begin
      cache_v = 1'b0; exp_data = 8'hFF; exp_terr = 1'b1;
    end
    check("stall_len", stall_seen, nwait + 2);
    cpu_cs   = 1'b0;
    rom_ok   = 1'($urandom);
    rom_data = 8'($urandom);
    tick(1'b0, 1'b0, a);
    $display("[TB] miss  addr=%05h lat=%0d stale=%0d stall_clk=%0d data=%02h tout_err=%0d",
             a, lat, stale, stall_seen, exp_data, exp_terr);
  endtask

  initial begin
    logic [AW-1:0] pool [4];
    logic [AW-1:0] ra;
    pool[0] = 17'h00123; pool[1] = 17'h00124; pool[2] = 17'h1F000; pool[3] = 17'h0BEEF;

    // Reset
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rom_cs", {31'd0, rom_cs}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_cpu_data", {24'd0, cpu_data}, 32'hFF);
    check("rst_tout_err", {31'd0, tout_err}, 32'd0);
    rstn = 1'b1;
    tick(1'b0, 1'b0, '0);
    $display("[TB] reset done");

    access(17'h00123, 4, 1'b0, 8'h3C);          // ok 5 clk after rom_cs, stall 7 clk
    access(17'h00123, 0, 1'b0, 8'h00);          // hit
    access(17'h00124, 0, 1'b1, 8'h5A);          // stale ok across address change
    access(17'h00123, 1, 1'b0, 8'hC3);          // single-entry cache: miss again
    access(17'h1F000, TOUT + 10, 1'b0, 8'h99);  // timeout
    access(17'h1F000, 2, 1'b0, 8'h77);          // same address misses after timeout
    access(17'h1F000, 0, 1'b0, 8'h00);          // now a hit

    for (int n = 0; n < 30; n++) begin
      ra = pool[$urandom_range(0, 3)];
      access(ra, int'($urandom_range(0, 7)), 1'($urandom), 8'($urandom));
    end

    // Reset in the middle of WAIT
    access(17'h00555, 1, 1'b0, 8'hA5);
    cpu_cs = 1'b1; cpu_addr = 17'h0ABCD; rom_ok = 1'b0;
    tick(1'b1, 1'b0, 17'h0ABCD);
    tick(1'b1, 1'b1, 17'h0ABCD);
    tick(1'b1, 1'b1, 17'h0ABCD);
    tick(1'b1, 1'b1, 17'h0ABCD);
    rstn = 1'b0; cpu_cs = 1'b0;
    tick(1'b1, 1'b1, 17'h0ABCD);
    rstn = 1'b1;
    cache_v = 1'b0; exp_data = 8'hFF; exp_terr = 1'b0;
    tick(1'b0, 1'b0, '0);
    $display("[TB] reset mid-WAIT done");
    access(17'h00555, 3, 1'b0, 8'h42);          // cache was invalidated by reset
    access(17'h00555, 0, 1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
